// File: rtl/grf_write_tracker_pkg.sv
// ============================================================================
// grf_write_tracker_pkg : shared constants for the GRF write tracker
// Rev 1.0
// ============================================================================
`default_nettype none

package grf_write_tracker_pkg;

    localparam int FWD_SEL_GRF = 0;

    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LOAD = 2;
    localparam int TNEW_LINK = 0;

endpackage

`default_nettype wire

// File: rtl/grf_write_tracker_if.sv
// ============================================================================
// grf_write_tracker_if : ID-stage hazard interface of the GRF write tracker
// Rev 1.0
// ============================================================================
`default_nettype none

interface grf_write_tracker_if #(
    parameter int READ_PORTS = 2,
    parameter int ADDR_W     = 5,
    parameter int TNEW_W     = 2,
    parameter int SEL_W      = 2
);
    logic                         id_valid;
    logic                         id_we;
    logic [ADDR_W-1:0]            id_addr;
    logic [TNEW_W-1:0]            id_tnew;
    logic                         flush;
    logic [READ_PORTS*ADDR_W-1:0] src_addr;
    logic [READ_PORTS*TNEW_W-1:0] src_tuse;
    logic                         stall;
    logic [READ_PORTS*SEL_W-1:0]  fwd_sel;
    logic [READ_PORTS-1:0]        pending;
`ifdef GRF_WRITE_TRACKER_PERF_EN
    logic [31:0]                  stall_cycles;
`endif

    modport master (
        output id_valid, id_we, id_addr, id_tnew, flush, src_addr, src_tuse,
`ifdef GRF_WRITE_TRACKER_PERF_EN
        input  stall_cycles,
`endif
        input  stall, fwd_sel, pending
    );

    modport slave (
        input  id_valid, id_we, id_addr, id_tnew, flush, src_addr, src_tuse,
`ifdef GRF_WRITE_TRACKER_PERF_EN
        output stall_cycles,
`endif
        output stall, fwd_sel, pending
    );

endinterface

`default_nettype wire

// File: rtl/grf_write_tracker_stage.sv
// ============================================================================
// grf_write_tracker_stage : one in-flight write record (valid/addr/tnew)
// Rev 1.0
// ============================================================================
`default_nettype none

module grf_write_tracker_stage #(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2,
    parameter bit DEC    = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_clear,
    input  wire logic              i_valid,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [TNEW_W-1:0] i_tnew,
    output logic                   o_valid,
    output logic [ADDR_W-1:0]      o_addr,
    output logic [TNEW_W-1:0]      o_tnew
);

    logic [TNEW_W-1:0] w_tnew_next;

    // Moving one stage deeper brings the result one cycle closer; never below 0.
    assign w_tnew_next = (DEC && (i_tnew != '0)) ? (i_tnew - TNEW_W'(1)) : i_tnew;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            o_valid <= 1'b0;
            o_addr  <= '0;
            o_tnew  <= '0;
        end else begin
            o_valid <= i_valid;
            o_addr  <= i_addr;
            o_tnew  <= w_tnew_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/grf_write_tracker.sv
// ============================================================================
// grf_write_tracker : in-flight GRF write records, ID stall and forward select
// Optional stall counter when GRF_WRITE_TRACKER_PERF_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module grf_write_tracker
    import grf_write_tracker_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int READ_PORTS = 2,
    parameter int ADDR_W     = 5,
    parameter int TNEW_W     = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    grf_write_tracker_if.slave bus
);

    localparam int SEL_W = $clog2(DEPTH + 1);

    logic              w_in_valid [1:DEPTH];
    logic [ADDR_W-1:0] w_in_addr  [1:DEPTH];
    logic [TNEW_W-1:0] w_in_tnew  [1:DEPTH];
    logic              w_valid    [1:DEPTH];
    logic [ADDR_W-1:0] w_addr     [1:DEPTH];
    logic [TNEW_W-1:0] w_tnew     [1:DEPTH];

    logic              w_load;
    logic              w_stall;
    logic [SEL_W-1:0]  w_sel  [READ_PORTS];
    logic              w_pend [READ_PORTS];
    logic              w_term [READ_PORTS];

    // A stalled ID instruction is not consumed: EX receives a bubble instead.
    assign w_load        = bus.id_valid & bus.id_we & (bus.id_addr != '0) & ~w_stall;
    assign w_in_valid[1] = w_load;
    assign w_in_addr[1]  = w_load ? bus.id_addr : '0;
    assign w_in_tnew[1]  = w_load ? bus.id_tnew : '0;

    for (genvar k = 2; k <= DEPTH; k++) begin : g_link
        assign w_in_valid[k] = w_valid[k-1];
        assign w_in_addr[k]  = w_addr[k-1];
        assign w_in_tnew[k]  = w_tnew[k-1];
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        grf_write_tracker_stage #(
            .ADDR_W (ADDR_W),
            .TNEW_W (TNEW_W),
            .DEC    (k > 1)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_clear (bus.flush),
            .i_valid (w_in_valid[k]),
            .i_addr  (w_in_addr[k]),
            .i_tnew  (w_in_tnew[k]),
            .o_valid (w_valid[k]),
            .o_addr  (w_addr[k]),
            .o_tnew  (w_tnew[k])
        );
    end

    // Oldest stage first so the youngest match overwrites the result.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            w_sel[p]  = SEL_W'(FWD_SEL_GRF);
            w_pend[p] = 1'b0;
            w_term[p] = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (w_valid[k] && (bus.src_addr[p*ADDR_W +: ADDR_W] != '0) &&
                    (w_addr[k] == bus.src_addr[p*ADDR_W +: ADDR_W])) begin
                    w_sel[p]  = SEL_W'(FWD_SEL_GRF);
                    w_pend[p] = 1'b0;
                    w_term[p] = 1'b0;
                    if (w_tnew[k] == '0) begin
                        w_sel[p] = SEL_W'(k);
                    end else if (w_tnew[k] <= bus.src_tuse[p*TNEW_W +: TNEW_W]) begin
                        w_pend[p] = 1'b1;
                    end else begin
                        w_term[p] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_stall     = 1'b0;
        bus.fwd_sel = '0;
        bus.pending = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            w_stall = w_stall | w_term[p];
            bus.fwd_sel[p*SEL_W +: SEL_W] = reset ? w_sel[p] : '0;
            bus.pending[p]                = reset & w_pend[p];
        end
        w_stall   = w_stall & bus.id_valid & reset;
        bus.stall = w_stall;
    end

`ifdef GRF_WRITE_TRACKER_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && !bus.flush && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_grf_write_tracker.sv
// ============================================================================
// tb_grf_write_tracker : directed scenarios plus randomized model comparison
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_grf_write_tracker;

    localparam int DEPTH = 3;
    localparam int RP    = 2;
    localparam int AW    = 5;
    localparam int TW    = 2;
    localparam int SW    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grf_write_tracker_if #(.READ_PORTS(RP), .ADDR_W(AW), .TNEW_W(TW), .SEL_W(SW)) bus ();

    grf_write_tracker #(.DEPTH(DEPTH), .READ_PORTS(RP), .ADDR_W(AW), .TNEW_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference records: index 1 = EX, DEPTH = last tracked stage.
    bit  mv [1:DEPTH];
    int  ma [1:DEPTH];
    int  mt [1:DEPTH];
    longint mcount = 0;

    function automatic void model_eval(output bit st, output int sel [RP], output bit pd [RP]);
        bit any_term = 1'b0;
        for (int p = 0; p < RP; p++) begin
            int src  = int'(bus.src_addr[p*AW +: AW]);
            int tuse = int'(bus.src_tuse[p*TW +: TW]);
            int hit  = 0;
            sel[p] = 0;
            pd[p]  = 1'b0;
            for (int k = 1; k <= DEPTH; k++)
                if (hit == 0 && mv[k] && src != 0 && ma[k] == src) hit = k;
            if (hit != 0 && reset) begin
                if (mt[hit] == 0)         sel[p] = hit;
                else if (mt[hit] <= tuse) pd[p]  = 1'b1;
                else                      any_term = 1'b1;
            end
        end
        st = reset && bus.id_valid && any_term;
    endfunction

    task automatic tick();
        bit st;
        int sel [RP];
        bit pd [RP];
        model_eval(st, sel, pd);
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) mv[k] = 1'b0;
            mcount = 0;
        end else if (bus.flush) begin
            for (int k = 1; k <= DEPTH; k++) mv[k] = 1'b0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                mv[k] = mv[k-1];
                ma[k] = ma[k-1];
                mt[k] = (mt[k-1] > 0) ? mt[k-1] - 1 : 0;
            end
            mv[1] = bus.id_valid && bus.id_we && bus.id_addr != 0 && !st;
            ma[1] = int'(bus.id_addr);
            mt[1] = int'(bus.id_tnew);
            if (st && mcount < 64'hFFFF_FFFF) mcount++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input bit we, input int a, input int t);
        bus.id_valid = v;
        bus.id_we    = we;
        bus.id_addr  = a[AW-1:0];
        bus.id_tnew  = t[TW-1:0];
    endtask

    task automatic set_src(input int p, input int a, input int tu);
        bus.src_addr[p*AW +: AW] = a[AW-1:0];
        bus.src_tuse[p*TW +: TW] = tu[TW-1:0];
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0);
        bus.flush    = 1'b0;
        bus.src_addr = '0;
        bus.src_tuse = '0;
    endtask

    task automatic reset_dut();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        set_src(0, 1, 0);
        #2;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_sel !== '0 || bus.pending !== '0)
            $display("FAIL reset_outputs: stall=%b fwd=%h pend=%b, required 0/0/0", bus.stall, bus.fwd_sel, bus.pending);
        else n_pass++;
        tick();
        reset = 1'b1;
        #2;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_sel !== '0 || bus.pending !== '0)
            $display("FAIL reset_records: stall=%b fwd=%h pend=%b, required 0/0/0", bus.stall, bus.fwd_sel, bus.pending);
        else n_pass++;
    endtask

    task automatic test_load_use();
        reset_dut();
        set_id(1, 1, 1, 2);
        tick();
        set_id(1, 1, 5, 1);
        set_src(0, 1, 1);
        #2;
        n_checks++;
        if (bus.stall !== 1'b1) $display("FAIL load_use_stall: stall=%b, required 1", bus.stall);
        else n_pass++;
        tick();
        #2;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.pending[0] !== 1'b1 || bus.fwd_sel[1:0] !== 2'd0)
            $display("FAIL load_use_pending: stall=%b pend=%b fwd=%h, required 0/1/0", bus.stall, bus.pending[0], bus.fwd_sel[1:0]);
        else n_pass++;
        tick();
        set_id(1, 0, 0, 0);
        set_src(0, 0, 0);
        set_src(1, 1, 1);
        #2;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.pending !== 2'b00 || bus.fwd_sel[3:2] !== 2'd3)
            $display("FAIL load_use_wb_fwd: stall=%b pend=%b fwd1=%0d, required 0/00/3", bus.stall, bus.pending, bus.fwd_sel[3:2]);
        else n_pass++;
    endtask

    task automatic test_branch();
        reset_dut();
        set_id(1, 1, 2, 1);
        tick();
        set_id(1, 0, 0, 0);
        set_src(0, 2, 0);
        #2;
        n_checks++;
        if (bus.stall !== 1'b1) $display("FAIL branch_stall: stall=%b, required 1", bus.stall);
        else n_pass++;
        tick();
        #2;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_sel[1:0] !== 2'd2 || bus.pending[0] !== 1'b0)
            $display("FAIL branch_fwd_mem: stall=%b fwd=%0d pend=%b, required 0/2/0", bus.stall, bus.fwd_sel[1:0], bus.pending[0]);
        else n_pass++;
    endtask

    task automatic test_youngest();
        reset_dut();
        set_id(1, 1, 3, 1);
        tick();
        set_id(1, 1, 3, 2);
        tick();
        set_id(1, 0, 0, 0);
        set_src(0, 3, 2);
        #2;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.pending[0] !== 1'b1 || bus.fwd_sel[1:0] !== 2'd0)
            $display("FAIL youngest_match: stall=%b pend=%b fwd=%0d, required 0/1/0", bus.stall, bus.pending[0], bus.fwd_sel[1:0]);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        reset_dut();
        set_id(1, 1, 0, 2);
        tick();
        set_src(0, 0, 0);
        set_src(1, 0, 0);
        #2;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_sel !== '0 || bus.pending !== '0)
            $display("FAIL zero_reg: stall=%b fwd=%h pend=%b, required 0/0/0", bus.stall, bus.fwd_sel, bus.pending);
        else n_pass++;
    endtask

    task automatic test_flush_stall();
        reset_dut();
        set_id(1, 1, 4, 2);
        tick();
        set_id(0, 0, 0, 0);
        set_src(0, 4, 0);
        #2;
        n_checks++;
        if (bus.stall !== 1'b0) $display("FAIL stall_needs_valid: stall=%b, required 0", bus.stall);
        else n_pass++;
        set_id(1, 0, 0, 0);
        bus.flush = 1'b1;
        #2;
        n_checks++;
        if (bus.stall !== 1'b1) $display("FAIL flush_stall_pre: stall=%b, required 1", bus.stall);
        else n_pass++;
        tick();
        bus.flush = 1'b0;
        #2;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.pending !== '0 || bus.fwd_sel !== '0)
            $display("FAIL flush_clears: stall=%b pend=%b fwd=%h, required 0/0/0", bus.stall, bus.pending, bus.fwd_sel);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        reset_dut();
        set_id(1, 1, 4, 2);
        tick();
        set_id(1, 0, 0, 0);
        set_src(0, 4, 0);
        #2;
        n_checks++;
        if (bus.stall !== 1'b1) $display("FAIL mid_stall_setup: stall=%b, required 1", bus.stall);
        else n_pass++;
        reset = 1'b0;
        #2;
        n_checks++;
        if (bus.stall !== 1'b0) $display("FAIL reset_drops_stall: stall=%b, required 0", bus.stall);
        else n_pass++;
        tick();
        reset = 1'b1;
        #2;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.pending !== '0 || bus.fwd_sel !== '0)
            $display("FAIL reset_mid_stall: stall=%b pend=%b fwd=%h, required 0/0/0", bus.stall, bus.pending, bus.fwd_sel);
        else n_pass++;
    endtask

`ifdef GRF_WRITE_TRACKER_PERF_EN
    task automatic test_perf();
        reset_dut();
        set_id(1, 1, 6, 3);
        tick();
        set_id(1, 0, 0, 0);
        set_src(0, 6, 0);
        repeat (3) tick();
        set_id(1, 1, 7, 2);
        set_src(0, 0, 0);
        tick();
        set_id(1, 0, 0, 0);
        set_src(0, 7, 0);
        repeat (3) tick();
        #2;
        n_checks++;
        if (bus.stall_cycles !== 32'd5) $display("FAIL perf_count: stall_cycles=%0d, required 5", bus.stall_cycles);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        bit st;
        int sel [RP];
        bit pd [RP];
        logic [RP*SW-1:0] efwd;
        logic [RP-1:0]    epd;
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) != 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3));
            for (int p = 0; p < RP; p++) set_src(p, $urandom_range(0, 3), $urandom_range(0, 3));
            #2;
            model_eval(st, sel, pd);
            for (int p = 0; p < RP; p++) begin
                efwd[p*SW +: SW] = sel[p][SW-1:0];
                epd[p]           = pd[p];
            end
            n_checks++;
            if (bus.stall !== st) $display("FAIL rand_stall c=%0d: stall=%b, required %b", c, bus.stall, st);
            else n_pass++;
            n_checks++;
            if (bus.fwd_sel !== efwd) $display("FAIL rand_fwd c=%0d: fwd=%h, required %h", c, bus.fwd_sel, efwd);
            else n_pass++;
            n_checks++;
            if (bus.pending !== epd) $display("FAIL rand_pend c=%0d: pend=%b, required %b", c, bus.pending, epd);
            else n_pass++;
`ifdef GRF_WRITE_TRACKER_PERF_EN
            n_checks++;
            if (bus.stall_cycles !== mcount[31:0])
                $display("FAIL rand_perf c=%0d: stall_cycles=%0d, required %0d", c, bus.stall_cycles, mcount);
            else n_pass++;
`endif
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        for (int k = 1; k <= DEPTH; k++) begin
            mv[k] = 1'b0;
            ma[k] = 0;
            mt[k] = 0;
        end
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_youngest();
        test_zero_reg();
        test_flush_stall();
        test_reset_mid_stall();
`ifdef GRF_WRITE_TRACKER_PERF_EN
        test_perf();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
